maze_block_reader: RTL and testbench
====================================

Name: maze_block_reader

Overview:
- Reads back an N x N pixel block from the video frame memory, starting at (bias_x, bias_y). This is the read-side counterpart of the block drawer.
- Compares every returned pixel with a latched reference colour and reports match statistics. The maze game uses these statistics for wall and collision checks before moving a sprite.
- Sits between the game controller and the read port of the framebuffer RAM.
- The read port has a fixed read latency of RD_LATENCY cycles.

Parameters:
- N, 8, block edge in pixels (N*N pixels scanned).
- X_W, 9, x coordinate width.
- Y_W, 8, y coordinate width.
- COLOR_W, 3, pixel colour width.
- X_MAX, 320, screen width; x >= X_MAX is off-screen.
- Y_MAX, 240, screen height; y >= Y_MAX is off-screen.
- RD_LATENCY, 1, framebuffer read latency in cycles (1..4).
- CNT_W, 7, match counter width; must satisfy 2^CNT_W > N*N.

Ports:
- clock  in  1  system clock; all logic is on its rising edge.
- resetn  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle request to scan a block.
- bias_x  in  X_W  block origin x.
- bias_y  in  Y_W  block origin y.
- match_color  in  COLOR_W  reference colour to compare against.
- rd_en  out  1  framebuffer read strobe.
- rd_x  out  X_W  read address x.
- rd_y  out  Y_W  read address y.
- rd_color  in  COLOR_W  read data, valid RD_LATENCY cycles after rd_en.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse when results are final.
- match_count  out  CNT_W  number of matching pixels.
- any_match  out  1  match_count != 0.
- all_match  out  1  match_count == N*N.
- offscreen  out  1  at least one block pixel lay off-screen.

Behaviour:
- Reset (resetn=0 at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0, as do dx, dy, the latency pipe and the accumulator.
  - Applies mid-scan: the scan is abandoned, no done is issued, and read data still in flight is discarded.
- IDLE:
  - start=1 latches bias_x, bias_y and match_color, clears the accumulator and the offscreen flag, and moves to READ.
  - busy=1 from the next cycle.
  - Result outputs keep their previous values until the clear.
- READ, one address per cycle for N*N cycles:
  - Scan order is row-major with dx fastest: dx = 0..N-1, then dy increments; dx and dy are 4-bit counters.
  - rd_x = bias_x + dx, truncated to X_W.
  - rd_y = bias_y + dy, truncated to Y_W.
  - Coordinate wrap through truncation is allowed; the resulting coordinate is then checked against X_MAX/Y_MAX.
  - If rd_x >= X_MAX or rd_y >= Y_MAX, the pixel is off-screen:
    - rd_en=0 for that cycle;
    - the pixel counts as a match (treated as a wall);
    - offscreen sets.
  - Otherwise rd_en=1.
  - After (dx,dy) = (N-1,N-1), go to DRAIN.
- Latency pipe:
  - A RD_LATENCY-deep shift register carries a {valid, offscreen} tag per issued slot.
  - When a tagged valid slot emerges, rd_color == match_color increments the accumulator.
  - An emerging off-screen tag increments the accumulator unconditionally.
  - rd_color is ignored in all other cycles.
- DRAIN: wait RD_LATENCY cycles for the pipe to empty, then go to DONE.
- DONE (one cycle):
  - done=1, busy=0.
  - match_count, any_match, all_match and offscreen are final and held stable until the next accepted start.
  - Return to IDLE.
- Timing: with start accepted at edge 0, the first rd_en is in cycle 1 and done is asserted in cycle N*N + RD_LATENCY + 1. For the defaults that is cycle 66.
- start while busy=1 is ignored and never queued.
- start in the DONE cycle is ignored.
- start in the cycle after done is accepted.
- Inputs bias_x, bias_y and match_color may change freely after start is accepted; the latched copies are used.
- Arithmetic:
  - Counter increments never exceed N*N.
  - any_match and all_match are registered, derived from the final count and updated in the same cycle as match_count.

Decomposition:
- Shared package maze_pkg holds:
  - SCREEN_W = 320, SCREEN_H = 240, BLOCK_N = 8, COLOR_W = 3;
  - colour constants COLOR_BLACK = 3'b000, COLOR_WALL = 3'b111;
  - the state enum {IDLE, READ, DRAIN, DONE}.
- One natural sub-module, block_scan_counter: the dx/dy row-major counter with a last flag. The draw side reuses it later.

Test Plan:
- All-black memory, bias = (40,40), match_color = 0, start → 64 rd_en pulses covering x 40..47 and y 40..47 in row-major order; done in cycle 66; match_count = 64, all_match = 1, offscreen = 0.
- Memory black except (43,45) = 7, bias = (40,40), match_color = 7 → match_count = 1, any_match = 1, all_match = 0.
- bias = (316,100), memory all black, match_color = 7 → rd_en low whenever x >= 320 (32 slots); match_count = 32, offscreen = 1, done still in cycle 66.
- start re-pulsed at cycles 10 and 65 during a scan → ignored, exactly one done; a start in the cycle after done begins a new scan and results clear.
- resetn low at cycle 20 of a scan → busy = 0 and match_count = 0 next cycle, no done within 100 cycles; a fresh start afterwards completes normally.
- RD_LATENCY = 2, memory model with 2-cycle latency, pattern with 10 matches → match_count = 10, done in cycle 67.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared maze constants, colours and the block-access state enum.
// Used by both the block reader and the block drawer.
package maze_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int BLOCK_N  = 8;
  localparam int COLOR_W  = 3;

  localparam logic [COLOR_W-1:0] COLOR_BLACK = 3'b000;
  localparam logic [COLOR_W-1:0] COLOR_WALL  = 3'b111;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

endpackage

// File: rtl/block_scan_counter.sv
// Row-major dx/dy walker over an N x N block, dx fastest; last flags (N-1,N-1).
// Zero latency: last reflects the current registered position; no backpressure.
module block_scan_counter #(
  parameter int N = 8
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       clear,
  input  logic       advance,
  output logic [3:0] dx,
  output logic [3:0] dy,
  output logic       last
);

  localparam logic [3:0] LAST = 4'(N - 1);

  logic [3:0] dx_q, dx_d;
  logic [3:0] dy_q, dy_d;

  always_comb begin
    dx_d = dx_q;
    dy_d = dy_q;
    if (clear) begin
      dx_d = 4'd0;
      dy_d = 4'd0;
    end else if (advance) begin
      if (dx_q == LAST) begin
        dx_d = 4'd0;
        dy_d = (dy_q == LAST) ? 4'd0 : dy_q + 4'd1;
      end else begin
        dx_d = dx_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      dx_q <= 4'd0;
      dy_q <= 4'd0;
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

  assign dx   = dx_q;
  assign dy   = dy_q;
  assign last = (dx_q == LAST) && (dy_q == LAST);

endmodule

// File: rtl/maze_block_reader.sv
// Scans an N x N framebuffer block and counts pixels equal to a latched colour.
// done arrives N*N+RD_LATENCY+1 cycles after start; start is ignored unless idle.
module maze_block_reader
  import maze_pkg::*;
#(
  parameter int N          = BLOCK_N,
  parameter int X_W        = 9,
  parameter int Y_W        = 8,
  parameter int COLOR_W    = maze_pkg::COLOR_W,
  parameter int X_MAX      = SCREEN_W,
  parameter int Y_MAX      = SCREEN_H,
  parameter int RD_LATENCY = 1,
  parameter int CNT_W      = 7
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic [X_W-1:0]     bias_x,
  input  logic [Y_W-1:0]     bias_y,
  input  logic [COLOR_W-1:0] match_color,
  output logic               rd_en,
  output logic [X_W-1:0]     rd_x,
  output logic [Y_W-1:0]     rd_y,
  input  logic [COLOR_W-1:0] rd_color,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   match_count,
  output logic               any_match,
  output logic               all_match,
  output logic               offscreen
);

  state_t               state_q, state_d;
  logic [X_W-1:0]       bias_x_q, bias_x_d;
  logic [Y_W-1:0]       bias_y_q, bias_y_d;
  logic [COLOR_W-1:0]   color_q, color_d;
  logic                 rd_en_q, rd_en_d;
  logic [X_W-1:0]       rd_x_q, rd_x_d;
  logic [Y_W-1:0]       rd_y_q, rd_y_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 any_q, any_d;
  logic                 all_q, all_d;
  logic                 off_q, off_d;
  logic [2:0]           drain_q, drain_d;
  logic [RD_LATENCY:0]  pipe_vld_q, pipe_vld_d;
  logic [RD_LATENCY:0]  pipe_off_q, pipe_off_d;

  logic                 scan_clear, scan_adv, scan_last;
  logic [3:0]           dx, dy;
  logic [X_W-1:0]       px;
  logic [Y_W-1:0]       py;
  logic                 pix_off, new_vld, new_off, hit;

  block_scan_counter #(.N(N)) u_scan (
    .clock   (clock),
    .resetn  (resetn),
    .clear   (scan_clear),
    .advance (scan_adv),
    .dx      (dx),
    .dy      (dy),
    .last    (scan_last)
  );

  // Coordinates wrap by truncation before the screen-bounds test.
  assign px      = bias_x_q + X_W'(dx);
  assign py      = bias_y_q + Y_W'(dy);
  assign pix_off = (px >= X_W'(X_MAX)) || (py >= Y_W'(Y_MAX));

  // Off-screen pixels count as wall hits without touching the read port.
  assign hit = pipe_off_q[RD_LATENCY] |
               (pipe_vld_q[RD_LATENCY] & (rd_color == color_q));

  always_comb begin
    state_d    = state_q;
    bias_x_d   = bias_x_q;
    bias_y_d   = bias_y_q;
    color_d    = color_q;
    rd_en_d    = 1'b0;
    rd_x_d     = rd_x_q;
    rd_y_d     = rd_y_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    count_d    = count_q;
    any_d      = any_q;
    all_d      = all_q;
    off_d      = off_q;
    drain_d    = drain_q;
    scan_clear = 1'b0;
    scan_adv   = 1'b0;
    new_vld    = 1'b0;
    new_off    = 1'b0;

    if (hit) begin
      count_d = count_q + CNT_W'(1);
      any_d   = 1'b1;
      all_d   = (count_d == CNT_W'(N * N));
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          bias_x_d   = bias_x;
          bias_y_d   = bias_y;
          color_d    = match_color;
          count_d    = '0;
          any_d      = 1'b0;
          all_d      = 1'b0;
          off_d      = 1'b0;
          busy_d     = 1'b1;
          scan_clear = 1'b1;
          state_d    = READ;
        end
      end
      READ: begin
        scan_adv = 1'b1;
        rd_x_d   = px;
        rd_y_d   = py;
        rd_en_d  = !pix_off;
        new_vld  = !pix_off;
        new_off  = pix_off;
        if (pix_off) off_d = 1'b1;
        if (scan_last) begin
          drain_d = 3'd0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_q == 3'(RD_LATENCY)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end else begin
          drain_d = drain_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    pipe_vld_d = {pipe_vld_q[RD_LATENCY-1:0], new_vld};
    pipe_off_d = {pipe_off_q[RD_LATENCY-1:0], new_off};
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= IDLE;
      bias_x_q   <= '0;
      bias_y_q   <= '0;
      color_q    <= '0;
      rd_en_q    <= 1'b0;
      rd_x_q     <= '0;
      rd_y_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= '0;
      any_q      <= 1'b0;
      all_q      <= 1'b0;
      off_q      <= 1'b0;
      drain_q    <= 3'd0;
      pipe_vld_q <= '0;
      pipe_off_q <= '0;
    end else begin
      state_q    <= state_d;
      bias_x_q   <= bias_x_d;
      bias_y_q   <= bias_y_d;
      color_q    <= color_d;
      rd_en_q    <= rd_en_d;
      rd_x_q     <= rd_x_d;
      rd_y_q     <= rd_y_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      count_q    <= count_d;
      any_q      <= any_d;
      all_q      <= all_d;
      off_q      <= off_d;
      drain_q    <= drain_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_off_q <= pipe_off_d;
    end
  end

  assign rd_en       = rd_en_q;
  assign rd_x        = rd_x_q;
  assign rd_y        = rd_y_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign match_count = count_q;
  assign any_match   = any_q;
  assign all_match   = all_q;
  assign offscreen   = off_q;

endmodule

// File: tb/tb_maze_block_reader.sv
// Bench for maze_block_reader: one instance with 1-cycle and one with 2-cycle read latency,
// both served from a shared frame model and checked against a per-scan reference model.
module tb_maze_block_reader;
  import maze_pkg::*;

  logic       clock;
  logic       resetn;
  logic [8:0] bias_x;
  logic [7:0] bias_y;
  logic [2:0] match_color;
  logic       start [2];
  logic       rd_en [2];
  logic [8:0] rd_x [2];
  logic [7:0] rd_y [2];
  logic [2:0] rd_color [2];
  logic       busy [2];
  logic       done [2];
  logic [6:0] match_count [2];
  logic       any_match [2];
  logic       all_match [2];
  logic       offscreen [2];

  logic [2:0] mem [0:76799];
  logic [2:0] stage_b;
  int total, bad;
  int prev_cnt [2];

  maze_block_reader #(.RD_LATENCY(1)) dut_a (
    .clock(clock), .resetn(resetn), .start(start[0]),
    .bias_x(bias_x), .bias_y(bias_y), .match_color(match_color),
    .rd_en(rd_en[0]), .rd_x(rd_x[0]), .rd_y(rd_y[0]), .rd_color(rd_color[0]),
    .busy(busy[0]), .done(done[0]), .match_count(match_count[0]),
    .any_match(any_match[0]), .all_match(all_match[0]), .offscreen(offscreen[0])
  );

  maze_block_reader #(.RD_LATENCY(2)) dut_b (
    .clock(clock), .resetn(resetn), .start(start[1]),
    .bias_x(bias_x), .bias_y(bias_y), .match_color(match_color),
    .rd_en(rd_en[1]), .rd_x(rd_x[1]), .rd_y(rd_y[1]), .rd_color(rd_color[1]),
    .busy(busy[1]), .done(done[1]), .match_count(match_count[1]),
    .any_match(any_match[1]), .all_match(all_match[1]), .offscreen(offscreen[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Read port models; garbage is returned whenever no valid read was issued.
  always @(posedge clock) begin
    rd_color[0] <= (rd_en[0] && rd_x[0] < 9'd320 && rd_y[0] < 8'd240) ?
                   mem[int'(rd_y[0]) * 320 + int'(rd_x[0])] : 3'($urandom);
    stage_b     <= (rd_en[1] && rd_x[1] < 9'd320 && rd_y[1] < 8'd240) ?
                   mem[int'(rd_y[1]) * 320 + int'(rd_x[1])] : 3'($urandom);
    rd_color[1] <= stage_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_scan(input bit en0, input bit en1, input int bx, input int by,
                          input int col, input int rs0, input int rs1, input int window);
    bit en [2];
    int ex_x[$], ex_y[$], ex_c[$];
    int exp_cnt, exp_off;
    int err [2], rd_n [2], done_n [2], done_at [2], busy_at_done [2];
    int r_cnt [2], r_any [2], r_all [2], r_off [2];
    int x, y;
    en[0] = en0;
    en[1] = en1;
    exp_cnt = 0;
    exp_off = 0;
    for (int dy = 0; dy < BLOCK_N; dy++) begin
      for (int dx = 0; dx < BLOCK_N; dx++) begin
        x = (bx + dx) % 512;
        y = (by + dy) % 256;
        if (x >= SCREEN_W || y >= SCREEN_H) begin
          exp_cnt++;
          exp_off = 1;
        end else begin
          ex_x.push_back(x);
          ex_y.push_back(y);
          ex_c.push_back(1 + dy * BLOCK_N + dx);
          if (mem[y * SCREEN_W + x] == 3'(col)) exp_cnt++;
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      err[d] = 0; rd_n[d] = 0; done_n[d] = 0; done_at[d] = -1; busy_at_done[d] = -1;
      r_cnt[d] = -1; r_any[d] = -1; r_all[d] = -1; r_off[d] = -1;
    end

    @(posedge clock); #1;
    for (int d = 0; d < 2; d++)
      if (en[d] && prev_cnt[d] >= 0) chk($sformatf("held_count[%0d]", d), 32'(match_count[d]), 32'(prev_cnt[d]));
    bias_x = 9'(bx);
    bias_y = 8'(by);
    match_color = 3'(col);
    start[0] = en0;
    start[1] = en1;
    @(posedge clock); #1;
    start[0] = 1'b0;
    start[1] = 1'b0;
    bias_x = 9'($urandom);
    bias_y = 8'($urandom);
    match_color = 3'($urandom);

    for (int rel = 0; rel < window; rel++) begin
      @(negedge clock);
      start[0] = en0 && (rel == rs0 || rel == rs1);
      start[1] = en1 && (rel == rs0 || rel == rs1);
      for (int d = 0; d < 2; d++) begin
        if (en[d]) begin
          if (rel == 0) begin
            chk($sformatf("clear_count[%0d]", d), 32'(match_count[d]), 32'd0);
            chk($sformatf("busy_cycle0[%0d]", d), 32'(busy[d]), 32'd1);
          end
          if (rd_en[d]) begin
            if (rd_n[d] >= ex_x.size() || int'(rd_x[d]) != ex_x[rd_n[d]] ||
                int'(rd_y[d]) != ex_y[rd_n[d]] || rel != ex_c[rd_n[d]]) err[d]++;
            rd_n[d]++;
          end
          if (done[d]) begin
            done_n[d]++;
            done_at[d] = rel;
            busy_at_done[d] = int'(busy[d]);
            r_cnt[d] = int'(match_count[d]);
            r_any[d] = int'(any_match[d]);
            r_all[d] = int'(all_match[d]);
            r_off[d] = int'(offscreen[d]);
          end
        end
      end
    end
    start[0] = 1'b0;
    start[1] = 1'b0;

    for (int d = 0; d < 2; d++) begin
      if (en[d]) begin
        chk($sformatf("rd_pulses[%0d]", d), 32'(rd_n[d]), 32'(ex_x.size()));
        chk($sformatf("rd_addr_seq_errors[%0d]", d), 32'(err[d]), 32'd0);
        chk($sformatf("done_pulses[%0d]", d), 32'(done_n[d]), 32'd1);
        chk($sformatf("done_cycle[%0d]", d), 32'(done_at[d]), 32'(BLOCK_N * BLOCK_N + d + 2));
        chk($sformatf("busy_at_done[%0d]", d), 32'(busy_at_done[d]), 32'd0);
        chk($sformatf("match_count[%0d]", d), 32'(r_cnt[d]), 32'(exp_cnt));
        chk($sformatf("any_match[%0d]", d), 32'(r_any[d]), 32'(exp_cnt != 0));
        chk($sformatf("all_match[%0d]", d), 32'(r_all[d]), 32'(exp_cnt == BLOCK_N * BLOCK_N));
        chk($sformatf("offscreen[%0d]", d), 32'(r_off[d]), 32'(exp_off));
        prev_cnt[d] = exp_cnt;
      end
    end
  endtask

  initial begin
    int ndone [2], nrd [2];
    total = 0;
    bad = 0;
    prev_cnt[0] = -1;
    prev_cnt[1] = -1;
    resetn = 1'b0;
    start[0] = 1'b0;
    start[1] = 1'b0;
    bias_x = '0;
    bias_y = '0;
    match_color = '0;
    for (int i = 0; i < 76800; i++) mem[i] = COLOR_BLACK;

    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int d = 0; d < 2; d++)
      chk($sformatf("reset_outputs[%0d]", d),
          32'({busy[d], done[d], rd_en[d], any_match[d], all_match[d], offscreen[d],
               match_count[d], rd_x[d], rd_y[d]}), 32'd0);
    resetn = 1'b1;

    // All-black block, reference black.
    run_scan(1, 1, 40, 40, 0, -1, -1, 80);
    // Single wall-coloured pixel inside the block.
    mem[45 * 320 + 43] = COLOR_WALL;
    run_scan(1, 1, 40, 40, 7, -1, -1, 80);
    mem[45 * 320 + 43] = COLOR_BLACK;
    // Right half of the block falls off the screen edge.
    run_scan(1, 1, 316, 100, 7, -1, -1, 80);
    // Ten scattered matches.
    for (int i = 0; i < 10; i++) mem[(50 + (i * 6) / 8) * 320 + 100 + (i * 6) % 8] = 3'd5;
    run_scan(1, 1, 100, 50, 5, -1, -1, 80);
    // Starts during a scan are dropped; a start right after done is accepted.
    run_scan(1, 0, 40, 40, 0, 10, 65, 67);
    run_scan(1, 0, 316, 100, 7, -1, -1, 80);

    // Reset in the middle of a scan.
    @(posedge clock); #1;
    bias_x = 9'd40;
    bias_y = 8'd40;
    match_color = 3'd0;
    start[0] = 1'b1;
    start[1] = 1'b1;
    @(posedge clock); #1;
    start[0] = 1'b0;
    start[1] = 1'b0;
    repeat (21) @(negedge clock);
    for (int d = 0; d < 2; d++) chk($sformatf("busy_before_reset[%0d]", d), 32'(busy[d]), 32'd1);
    resetn = 1'b0;
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("busy_after_reset[%0d]", d), 32'(busy[d]), 32'd0);
      chk($sformatf("count_after_reset[%0d]", d), 32'(match_count[d]), 32'd0);
      ndone[d] = 0;
      nrd[d] = 0;
      prev_cnt[d] = 0;
    end
    resetn = 1'b1;
    repeat (100) begin
      @(negedge clock);
      for (int d = 0; d < 2; d++) begin
        ndone[d] += int'(done[d]);
        nrd[d] += int'(rd_en[d]);
      end
    end
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("done_after_reset[%0d]", d), 32'(ndone[d]), 32'd0);
      chk($sformatf("rd_after_reset[%0d]", d), 32'(nrd[d]), 32'd0);
    end
    run_scan(1, 1, 100, 50, 5, -1, -1, 80);

    // Random frame contents, origins (including wrap past 511/255) and colours.
    for (int i = 0; i < 76800; i++) mem[i] = 3'($urandom);
    for (int k = 0; k < 4; k++)
      run_scan(1, 1, (k == 0) ? 508 : int'($urandom_range(0, 511)),
               (k == 1) ? 252 : int'($urandom_range(0, 255)),
               int'($urandom_range(0, 7)), -1, -1, 80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
